// File: rtl/riscv_rf_pkg.sv
// Shared limits and helpers for the scoreboarded register file.
// Port selection is by highest index, and the FP bank is chosen by the address MSB.
package riscv_rf_pkg;

  localparam int MAX_RPORTS  = 4;
  localparam int MAX_WPORTS  = 3;
  localparam int WPORT_IDX_W = 2;

  typedef struct packed {
    logic                   vld;
    logic [WPORT_IDX_W-1:0] idx;
  } wsel_t;

  // The last matching port in the scan is kept, so the highest index wins.
  function automatic wsel_t wsel_hi(input logic [MAX_WPORTS-1:0] hit);
    wsel_t r;
    r = '0;
    for (int p = 0; p < MAX_WPORTS; p++) begin
      if (hit[p]) begin
        r.vld = 1'b1;
        r.idx = WPORT_IDX_W'(p);
      end
    end
    return r;
  endfunction

  function automatic logic bank_sel(input logic msb, input logic fpu_en);
    return msb & fpu_en;
  endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Busy-bit scoreboard for long-latency producers, plus the count of busy
// registers and a registered write-collision flag.
module riscv_rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int NREGS      = 64,
  parameter int IDXW       = 6,
  parameter int NUM_WPORTS = 2,
  parameter int CNT_W      = 7
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREGS-1:0]                    set_i,
  input  logic [NREGS-1:0]                    clr_i,
  input  logic [NUM_WPORTS-1:0]               we_i,
  input  logic [NUM_WPORTS-1:0][IDXW-1:0]     widx_i,
  output logic [NREGS-1:0]                    busy_o,
  output logic [CNT_W-1:0]                    busy_cnt_o,
  output logic                                wcoll_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coll_q, coll_d;

  // Set is applied after clear so a same-cycle reserve keeps the bit high.
  always_comb begin
    busy_d = (busy_q & ~clr_i) | set_i;
    cnt_d  = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_comb begin
    coll_d = 1'b0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      for (int q = p + 1; q < NUM_WPORTS; q++) begin
        if (we_i[p] && we_i[q] && (widx_i[p] == widx_i[q])) begin
          coll_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      coll_q <= coll_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;
  assign wcoll_o    = coll_q;

endmodule

// File: rtl/riscv_register_file_sb.sv
// Integer/FP register file with N read ports, M write ports, optional
// same-cycle write bypass, and a busy scoreboard for late write-backs.
module riscv_register_file_sb
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FPU        = 0,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       test_en_i,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH:0]        raddr_i,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]      rdata_o,
  output logic [NUM_RPORTS-1:0]                      rbusy_o,
  input  logic [NUM_WPORTS-1:0][ADDR_WIDTH:0]        waddr_i,
  input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]      wdata_i,
  input  logic [NUM_WPORTS-1:0]                      we_i,
  input  logic                                       rsv_i,
  input  logic [ADDR_WIDTH:0]                        rsv_addr_i,
  output logic [ADDR_WIDTH+1:0]                      busy_cnt_o,
  output logic                                       wcoll_o
);

  localparam int IDXW  = ADDR_WIDTH + 1;
  localparam int NREGS = 2 ** IDXW;
  localparam int CNT_W = ADDR_WIDTH + 2;

  if (NUM_RPORTS < 1 || NUM_RPORTS > MAX_RPORTS) begin : g_bad_rports
    $error("NUM_RPORTS out of range");
  end
  if (NUM_WPORTS < 1 || NUM_WPORTS > MAX_WPORTS) begin : g_bad_wports
    $error("NUM_WPORTS out of range");
  end

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // With FPU=0 the bank bit is forced low, so the upper half never gets
  // written and stays a constant zero.
  function automatic logic [IDXW-1:0] to_idx(input logic [ADDR_WIDTH:0] a);
    return {bank_sel(a[ADDR_WIDTH], FPU != 0), a[ADDR_WIDTH-1:0]};
  endfunction

  function automatic wsel_t port_sel(input logic [IDXW-1:0]                   target,
                                     input logic [NUM_WPORTS-1:0]             we,
                                     input logic [NUM_WPORTS-1:0][ADDR_WIDTH:0] wa);
    logic [MAX_WPORTS-1:0] hit;
    hit = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      hit[p] = we[p] && (to_idx(wa[p]) == target) && (target != '0);
    end
    return wsel_hi(hit);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] port_data(
      input logic [WPORT_IDX_W-1:0]                idx,
      input logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (idx == WPORT_IDX_W'(p)) d = wd[p];
    end
    return d;
  endfunction

  logic [DATA_WIDTH-1:0]          mem_q [NREGS];
  logic [DATA_WIDTH-1:0]          mem_d [NREGS];
  wsel_t                          wsel  [NREGS];
  logic [NREGS-1:0]               set_vec, clr_vec, busy;
  logic [NUM_WPORTS-1:0][IDXW-1:0] widx;

  for (genvar p = 0; p < NUM_WPORTS; p++) begin : g_widx
    assign widx[p] = to_idx(waddr_i[p]);
  end

  // Per-register write decode; x0 never matches, so it keeps its reset zero.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign wsel[i]    = port_sel(IDXW'(i), we_i, waddr_i);
    assign mem_d[i]   = wsel[i].vld ? port_data(wsel[i].idx, wdata_i) : mem_q[i];
    assign clr_vec[i] = wsel[i].vld;
    assign set_vec[i] = rsv_i && (to_idx(rsv_addr_i) == IDXW'(i)) && (i != 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
    logic [IDXW-1:0] ridx;
    wsel_t           rsel;
    assign ridx       = to_idx(raddr_i[k]);
    assign rsel       = port_sel(ridx, we_i, waddr_i);
    assign rdata_o[k] = (ridx == '0) ? '0 :
                        ((BYPASS != 0) && rsel.vld) ? port_data(rsel.idx, wdata_i) :
                        mem_q[ridx];
    assign rbusy_o[k] = busy[ridx];
  end

  riscv_rf_scoreboard #(
    .NREGS      (NREGS),
    .IDXW       (IDXW),
    .NUM_WPORTS (NUM_WPORTS),
    .CNT_W      (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (set_vec),
    .clr_i      (clr_vec),
    .we_i       (we_i),
    .widx_i     (widx),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt_o),
    .wcoll_o    (wcoll_o)
  );

endmodule

// File: tb/tb_riscv_register_file_sb.sv
// Directed bench: three register-file variants (bypass int, no-bypass int,
// bypass int+FP) driven by shared stimulus, each checked against fixed values.
module tb_riscv_register_file_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_en = 1'b0;
  logic [2:0][5:0]  raddr = '0;
  logic [1:0][5:0]  waddr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0]       we = '0;
  logic             rsv = 1'b0;
  logic [5:0]       rsv_addr = '0;

  logic [2:0][31:0] rdata_a, rdata_b, rdata_f;
  logic [2:0]       rbusy_a, rbusy_b, rbusy_f;
  logic [6:0]       cnt_a, cnt_b, cnt_f;
  logic             wcoll_a, wcoll_b, wcoll_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_register_file_sb #(.FPU(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata_a),
    .rbusy_o(rbusy_a), .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_i(rsv),
    .rsv_addr_i(rsv_addr), .busy_cnt_o(cnt_a), .wcoll_o(wcoll_a));

  riscv_register_file_sb #(.FPU(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata_b),
    .rbusy_o(rbusy_b), .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_i(rsv),
    .rsv_addr_i(rsv_addr), .busy_cnt_o(cnt_b), .wcoll_o(wcoll_b));

  riscv_register_file_sb #(.FPU(1), .BYPASS(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata_f),
    .rbusy_o(rbusy_f), .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_i(rsv),
    .rsv_addr_i(rsv_addr), .busy_cnt_o(cnt_f), .wcoll_o(wcoll_f));

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (cnt_a !== 7'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
    checks++; if (wcoll_a !== 1'b0) begin errors++; $display("FAIL reset_wcoll got=%b exp=0", wcoll_a); end
    checks++; if (rbusy_a !== 3'b000) begin errors++; $display("FAIL reset_rbusy got=%b exp=000", rbusy_a); end
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < 32; r++) begin
      raddr[0] = 6'(r);
      #1;
      checks++;
      if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL reset_read x%0d got=%h exp=0", r, rdata_a[0]); end
    end
    waddr[0] = 6'd0; wdata[0] = 32'hDEADBEEF; we = 2'b01; raddr[0] = 6'd0;
    #1;
    checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rdata_a[0]); end
    tick();
    we = 2'b00;
    #1;
    checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL x0_read_a got=%h exp=0", rdata_a[0]); end
    checks++; if (rdata_b[0] !== 32'h0) begin errors++; $display("FAIL x0_read_b got=%h exp=0", rdata_b[0]); end
  endtask

  task automatic test_collision();
    waddr[0] = 6'd5; waddr[1] = 6'd5; wdata[0] = 32'h11; wdata[1] = 32'h22; we = 2'b11;
    raddr[0] = 6'd5;
    #1;
    checks++; if (rdata_a[0] !== 32'h22) begin errors++; $display("FAIL coll_bypass got=%h exp=22", rdata_a[0]); end
    checks++; if (rdata_b[0] !== 32'h0) begin errors++; $display("FAIL coll_nobypass got=%h exp=0", rdata_b[0]); end
    tick();
    we = 2'b00;
    #1;
    checks++; if (rdata_a[0] !== 32'h22) begin errors++; $display("FAIL coll_store_a got=%h exp=22", rdata_a[0]); end
    checks++; if (rdata_b[0] !== 32'h22) begin errors++; $display("FAIL coll_store_b got=%h exp=22", rdata_b[0]); end
    checks++; if (wcoll_a !== 1'b1) begin errors++; $display("FAIL coll_flag got=%b exp=1", wcoll_a); end
    tick();
    checks++; if (wcoll_a !== 1'b0) begin errors++; $display("FAIL coll_idle got=%b exp=0", wcoll_a); end
    waddr[0] = 6'd0; waddr[1] = 6'd0; we = 2'b11;
    tick();
    we = 2'b00;
    #1;
    checks++; if (wcoll_a !== 1'b1) begin errors++; $display("FAIL coll_x0 got=%b exp=1", wcoll_a); end
    waddr[0] = 6'd1; waddr[1] = 6'd2; we = 2'b11;
    tick();
    we = 2'b00;
    #1;
    checks++; if (wcoll_a !== 1'b0) begin errors++; $display("FAIL coll_distinct got=%b exp=0", wcoll_a); end
  endtask

  task automatic test_bypass();
    waddr[0] = 6'd7; wdata[0] = 32'hA5A5; we = 2'b01; raddr[1] = 6'd7;
    #1;
    checks++; if (rdata_a[1] !== 32'hA5A5) begin errors++; $display("FAIL byp_on got=%h exp=a5a5", rdata_a[1]); end
    checks++; if (rdata_b[1] !== 32'h0) begin errors++; $display("FAIL byp_off got=%h exp=0", rdata_b[1]); end
    tick();
    we = 2'b00;
    #1;
    checks++; if (rdata_b[1] !== 32'hA5A5) begin errors++; $display("FAIL byp_off_next got=%h exp=a5a5", rdata_b[1]); end
  endtask

  task automatic test_scoreboard();
    raddr[2] = 6'd9; rsv = 1'b1; rsv_addr = 6'd9;
    #1;
    checks++; if (rbusy_a[2] !== 1'b0) begin errors++; $display("FAIL sb_not_bypassed got=%b exp=0", rbusy_a[2]); end
    tick();
    rsv = 1'b0;
    #1;
    checks++; if (rbusy_a[2] !== 1'b1) begin errors++; $display("FAIL sb_busy got=%b exp=1", rbusy_a[2]); end
    checks++; if (cnt_a !== 7'd1) begin errors++; $display("FAIL sb_cnt1 got=%0d exp=1", cnt_a); end
    waddr[0] = 6'd9; wdata[0] = 32'h3; we = 2'b01;
    #1;
    checks++; if (rbusy_a[2] !== 1'b1) begin errors++; $display("FAIL sb_busy_during_wr got=%b exp=1", rbusy_a[2]); end
    tick();
    we = 2'b00;
    #1;
    checks++; if (rbusy_a[2] !== 1'b0) begin errors++; $display("FAIL sb_released got=%b exp=0", rbusy_a[2]); end
    checks++; if (cnt_a !== 7'd0) begin errors++; $display("FAIL sb_cnt0 got=%0d exp=0", cnt_a); end
    checks++; if (rdata_b[2] !== 32'h3) begin errors++; $display("FAIL sb_data got=%h exp=3", rdata_b[2]); end
    raddr[2] = 6'd0; rsv = 1'b1; rsv_addr = 6'd0;
    tick();
    rsv = 1'b0;
    #1;
    checks++; if (cnt_a !== 7'd0) begin errors++; $display("FAIL sb_x0_cnt got=%0d exp=0", cnt_a); end
    checks++; if (rbusy_a[2] !== 1'b0) begin errors++; $display("FAIL sb_x0_busy got=%b exp=0", rbusy_a[2]); end
    raddr[2] = 6'd9; rsv = 1'b1; rsv_addr = 6'd9;
    tick();
    tick();
    rsv = 1'b0;
    #1;
    checks++; if (cnt_a !== 7'd1) begin errors++; $display("FAIL sb_double_cnt got=%0d exp=1", cnt_a); end
    checks++; if (rbusy_a[2] !== 1'b1) begin errors++; $display("FAIL sb_double_busy got=%b exp=1", rbusy_a[2]); end
  endtask

  task automatic test_rsv_write();
    rsv = 1'b1; rsv_addr = 6'd9; waddr[0] = 6'd9; wdata[0] = 32'h4; we = 2'b01;
    tick();
    rsv = 1'b0; we = 2'b00;
    #1;
    checks++; if (rdata_b[2] !== 32'h4) begin errors++; $display("FAIL rw_data got=%h exp=4", rdata_b[2]); end
    checks++; if (rbusy_a[2] !== 1'b1) begin errors++; $display("FAIL rw_busy got=%b exp=1", rbusy_a[2]); end
    checks++; if (cnt_a !== 7'd1) begin errors++; $display("FAIL rw_cnt got=%0d exp=1", cnt_a); end
    we = 2'b01;
    tick();
    we = 2'b00;
    #1;
    checks++; if (cnt_a !== 7'd0) begin errors++; $display("FAIL rw_clear got=%0d exp=0", cnt_a); end
    rsv = 1'b1; rsv_addr = 6'd10;
    tick();
    rsv_addr = 6'd11;
    tick();
    rsv = 1'b0;
    #1;
    checks++; if (cnt_a !== 7'd2) begin errors++; $display("FAIL rw_cnt2 got=%0d exp=2", cnt_a); end
    waddr[0] = 6'd10; waddr[1] = 6'd11; wdata[0] = 32'h10; wdata[1] = 32'h11; we = 2'b11;
    tick();
    we = 2'b00;
    #1;
    checks++; if (cnt_a !== 7'd0) begin errors++; $display("FAIL rw_dual_clear_a got=%0d exp=0", cnt_a); end
    checks++; if (cnt_f !== 7'd0) begin errors++; $display("FAIL rw_dual_clear_f got=%0d exp=0", cnt_f); end
  endtask

  task automatic test_fpu();
    waddr[0] = 6'h20; wdata[0] = 32'h3F800000; we = 2'b01;
    tick();
    we = 2'b00; raddr[0] = 6'h00; raddr[1] = 6'h20;
    #1;
    checks++; if (rdata_f[0] !== 32'h0) begin errors++; $display("FAIL fp_x0 got=%h exp=0", rdata_f[0]); end
    checks++; if (rdata_f[1] !== 32'h3F800000) begin errors++; $display("FAIL fp_f0 got=%h exp=3f800000", rdata_f[1]); end
    checks++; if (rdata_a[1] !== 32'h0) begin errors++; $display("FAIL fp_ignored_msb got=%h exp=0", rdata_a[1]); end
    rsv = 1'b1; rsv_addr = 6'h23;
    tick();
    rsv_addr = 6'h20;
    tick();
    rsv = 1'b0; raddr[2] = 6'h23;
    #1;
    checks++; if (rbusy_f[2] !== 1'b1) begin errors++; $display("FAIL fp_f3_busy got=%b exp=1", rbusy_f[2]); end
    checks++; if (cnt_f !== 7'd2) begin errors++; $display("FAIL fp_cnt got=%0d exp=2", cnt_f); end
    waddr[0] = 6'h24; wdata[0] = 32'h1; we = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cnt_f !== 7'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", cnt_f); end
    checks++; if (rbusy_f[2] !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", rbusy_f[2]); end
    checks++; if (rdata_f[1] !== 32'h0) begin errors++; $display("FAIL arst_f0 got=%h exp=0", rdata_f[1]); end
    we = 2'b00;
    tick();
    rst_n = 1'b1;
    raddr[0] = 6'd5;
    tick();
    checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL arst_x5 got=%h exp=0", rdata_a[0]); end
    checks++; if (rdata_f[1] !== 32'h0) begin errors++; $display("FAIL arst_f0_after got=%h exp=0", rdata_f[1]); end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_rsv_write();
    test_fpu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_register_file_sb.md
# riscv_register_file_sb

Parametrised integer/FP register file with N read ports, M write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for long-latency producers (LSU, FPU, divider). It sits in the ID stage and replaces the fixed 3-read/2-write file. Decode reserves a destination on issue and stalls on busy sources. Late write-backs release the reservation.

## Interface
- ADDR_WIDTH, 5: per-bank register index width; NUM_WORDS = 2**ADDR_WIDTH per bank.
- DATA_WIDTH, 32: register width.
- FPU, 0: 1 instantiates the FP bank. Address MSB (bit ADDR_WIDTH) selects FP when 1. With FPU=0 the MSB is ignored and all accesses go to the integer bank.
- NUM_RPORTS, 3: read port count, 1..4.
- NUM_WPORTS, 2: write port count, 1..3.
- BYPASS, 1: 1 returns same-cycle write data on reads.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- test_en_i  in  1  scan mode; no functional effect.
- raddr_i  in  NUM_RPORTS×(ADDR_WIDTH+1)  read addresses.
- rdata_o  out  NUM_RPORTS×DATA_WIDTH  read data.
- rbusy_o  out  NUM_RPORTS  addressed register is reserved.
- waddr_i  in  NUM_WPORTS×(ADDR_WIDTH+1)  write addresses.
- wdata_i  in  NUM_WPORTS×DATA_WIDTH  write data.
- we_i  in  NUM_WPORTS  write enables.
- rsv_i  in  1  reserve a destination.
- rsv_addr_i  in  ADDR_WIDTH+1  address to reserve.
- busy_cnt_o  out  ADDR_WIDTH+2  number of registers currently reserved.
- wcoll_o  out  1  registered flag: two or more write ports hit the same address last cycle.

## Operation
- Integer x0 reads 0. Writes and reservations to x0 are dropped. x0 is never busy. The FP register f0 is a normal register.
- Writes commit at posedge. If several ports target the same register in one cycle, the highest port index wins.
- Reads are combinational from storage.
- With BYPASS=1: if any enabled write port targets raddr this cycle, rdata returns that wdata, applying the same highest-index priority. x0 still returns 0.
- Scoreboard: one busy bit per register.
  - A reservation (rsv_i) sets the bit at posedge.
  - Any enabled write to the address clears it at posedge.
  - Reserve and write to the same address in the same cycle: reserve wins and the bit stays set. The write data still commits.
  - Reserving an already-busy register leaves it busy and raises no error.
- rbusy_o[k] is the current busy bit of raddr_i[k], from registered state only.
- busy_cnt_o is a registered count of set busy bits, updated in the same cycle as the bits. Range 0..2*NUM_WORDS-1 with FPU=1.
- wcoll_o is set at posedge when ≥2 enabled write ports carried equal addresses, and is cleared otherwise. The x0 address counts toward a collision.

## Timing
- Reset: all storage 0, all busy bits 0, busy_cnt_o=0, wcoll_o=0. Asserting reset mid-operation clears all of them immediately, asynchronously.
- Write latency: data is readable from storage in the cycle after the write. With BYPASS=1 it is readable in the same cycle.
- rsv_i at edge T: rbusy_o is high from T+1. A write at edge T+k clears it, and rbusy_o is low from T+k+1.
- rbusy_o and busy_cnt_o are never bypassed.
- busy_cnt_o follows the bit changes with 0 extra cycles. A net change of +1, 0 or −(NUM_WPORTS) per cycle is possible.

## Structure
- riscv_rf_pkg holds:
  - localparams for the MAX_RPORTS/MAX_WPORTS limits;
  - a function for highest-index write-port selection;
  - a bank_sel helper for the address MSB.
- The sub-module riscv_rf_scoreboard holds the busy bits, busy_cnt_o and the wcoll_o flag. It takes the decoded set/clear vectors and the write addresses.
- Storage, the write decode and the bypass muxes stay in the top module, generated per port.

## Test plan
- Reset, then read all 32 integer registers: all return 0. Write x0=0xDEADBEEF, then read x0: returns 0.
- Write port 0 and port 1 to x5 in the same cycle with 0x11 and 0x22: x5 reads 0x22 and wcoll_o=1 next cycle. An idle cycle follows: wcoll_o=0.
- BYPASS=1: write x7=0xA5A5 and read x7 in the same cycle: returns 0xA5A5. BYPASS=0: returns the old value 0.
- Reserve x9: rbusy_o high from the next cycle and busy_cnt_o=1. Write x9=0x3: rbusy_o low the next cycle and busy_cnt_o=0.
- Reserve x9 and write x9=0x4 in the same cycle: x9=0x4, busy stays 1, busy_cnt_o=1.
- FPU=1: write address 0x20 (f0)=0x3F800000. Reads of x0 return 0 and reads of f0 return 0x3F800000. Reserve f3, then assert rst_n low mid-stream: all busy bits, busy_cnt_o and storage return to 0.
